// File: rtl/ysyx_25060170_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_lsu
//
// Load/store unit at the output of the EX/LS pipeline register. A memory
// instruction starts a request/grant/response transaction with data memory;
// the result (formatted load data or the ALU result) is registered into the
// bundle sent to WB. Non-memory instructions pass through in one cycle.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   ls_*                registered LS-stage bundle from the EX/LS register
//   ls_ready            1 = LS busy, EX/LS register must hold (combinational)
//   mem_req/addr/wen/wdata/wmask   request channel to data memory
//   mem_gnt             request accepted
//   mem_rvalid/rdata    read data valid (or write ack) and read word
//   wb_*                registered bundle toward WB
//   lsu_misalign        one-cycle pulse alongside wb_valid for a misaligned op
// ---------------------------------------------------------------------------
module ysyx_25060170_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic [XLEN-1:0] ls_inst,
  input  logic [XLEN-1:0] ls_pc,
  input  logic [XLEN-1:0] ls_exu_res,
  input  logic [XLEN-1:0] ls_store_data,
  input  logic [3:0]      ls_lsctl,
  input  logic [1:0]      ls_wbctl,
  input  logic            ls_rd_ena,
  input  logic [4:0]      ls_rd_addr,
  output logic            ls_ready,

  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,

  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic [XLEN-1:0] wb_inst,
  output logic            wb_rd_ena,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_rd_data,
  output logic [1:0]      wb_wbctl,
  output logic            lsu_misalign
);

  // Memory op codes
  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  // Access size encoding
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Decode of the incoming LS bundle
  // ---------------------------------------------------------------------
  logic       dec_load;
  logic       dec_store;
  logic       dec_mem;
  logic       dec_uns;
  logic [1:0] dec_size;
  logic [1:0] dec_off;
  logic       dec_misalign;

  assign dec_off = ls_exu_res[1:0];

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_uns   = 1'b0;
    dec_size  = SZ_W;
    case (ls_lsctl)
      OP_LB:   begin dec_load  = 1'b1; dec_size = SZ_B; end
      OP_LH:   begin dec_load  = 1'b1; dec_size = SZ_H; end
      OP_LW:   begin dec_load  = 1'b1; dec_size = SZ_W; end
      OP_LBU:  begin dec_load  = 1'b1; dec_size = SZ_B; dec_uns = 1'b1; end
      OP_LHU:  begin dec_load  = 1'b1; dec_size = SZ_H; dec_uns = 1'b1; end
      OP_SB:   begin dec_store = 1'b1; dec_size = SZ_B; end
      OP_SH:   begin dec_store = 1'b1; dec_size = SZ_H; end
      OP_SW:   begin dec_store = 1'b1; dec_size = SZ_W; end
      default: ;
    endcase
  end

  assign dec_mem      = dec_load | dec_store;
  assign dec_misalign = dec_mem &
                        (((dec_size == SZ_H) && dec_off[0]) ||
                         ((dec_size == SZ_W) && (dec_off != 2'b00)));

  // ---------------------------------------------------------------------
  // Store lane formatting: data is replicated so that whichever byte lanes
  // the strobe selects already carry the right bytes.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_mask;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_st_lane
      localparam logic [1:0] LANE = 2'(gi);

      assign st_wdata[8*gi +: 8] =
          (dec_size == SZ_B) ? ls_store_data[7:0] :
          (dec_size == SZ_H) ? ls_store_data[8*(gi%2) +: 8] :
                               ls_store_data[8*gi +: 8];

      assign st_mask[gi] =
          (dec_size == SZ_B) ? (dec_off == LANE) :
          (dec_size == SZ_H) ? (dec_off[1] == LANE[1]) :
                               1'b1;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Load formatting: pick the addressed byte/halfword and extend it.
  // ---------------------------------------------------------------------
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] word,
                                               input logic [1:0]      off,
                                               input logic [1:0]      size,
                                               input logic            uns);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [XLEN-1:0] res;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    res = uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    res = uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Request registers, captured load data and WB bundle
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] req_addr_q,  req_addr_d;
  logic            req_wen_q,   req_wen_d;
  logic [3:0]      req_wmask_q, req_wmask_d;
  logic [XLEN-1:0] req_wdata_q, req_wdata_d;
  logic [1:0]      req_size_q,  req_size_d;
  logic            req_uns_q,   req_uns_d;
  logic [1:0]      req_off_q,   req_off_d;
  logic [XLEN-1:0] ld_data_q,   ld_data_d;

  logic            wb_valid_q,   wb_valid_d;
  logic [XLEN-1:0] wb_pc_q,      wb_pc_d;
  logic [XLEN-1:0] wb_inst_q,    wb_inst_d;
  logic            wb_rd_ena_q,  wb_rd_ena_d;
  logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;
  logic [XLEN-1:0] wb_rd_data_q, wb_rd_data_d;
  logic [1:0]      wb_wbctl_q,   wb_wbctl_d;
  logic            misalign_q,   misalign_d;

  logic            busy;

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;

    req_addr_d   = req_addr_q;
    req_wen_d    = req_wen_q;
    req_wmask_d  = req_wmask_q;
    req_wdata_d  = req_wdata_q;
    req_size_d   = req_size_q;
    req_uns_d    = req_uns_q;
    req_off_d    = req_off_q;
    ld_data_d    = ld_data_q;

    // wb fields hold stale values unless a result is written this edge
    wb_valid_d   = 1'b0;
    misalign_d   = 1'b0;
    wb_pc_d      = wb_pc_q;
    wb_inst_d    = wb_inst_q;
    wb_rd_ena_d  = wb_rd_ena_q;
    wb_rd_addr_d = wb_rd_addr_q;
    wb_rd_data_d = wb_rd_data_q;
    wb_wbctl_d   = wb_wbctl_q;

    case (state_q)
      S_IDLE: begin
        if (!dec_mem || dec_misalign) begin
          // Single-cycle retire: ALU pass-through or misaligned trap
          wb_pc_d      = ls_pc;
          wb_inst_d    = ls_inst;
          wb_rd_addr_d = ls_rd_addr;
          wb_rd_data_d = ls_exu_res;
          wb_wbctl_d   = ls_wbctl;
          if (dec_misalign) begin
            wb_valid_d  = 1'b1;
            wb_rd_ena_d = 1'b0;
            misalign_d  = 1'b1;
          end else begin
            wb_valid_d  = (ls_inst != '0);
            wb_rd_ena_d = ls_rd_ena;
          end
        end else begin
          busy        = 1'b1;
          req_addr_d  = {ls_exu_res[XLEN-1:2], 2'b00};
          req_wen_d   = dec_store;
          req_wmask_d = dec_store ? st_mask  : 4'b0000;
          req_wdata_d = dec_store ? st_wdata : '0;
          req_size_d  = dec_size;
          req_uns_d   = dec_uns;
          req_off_d   = dec_off;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        busy = 1'b1;
        if (mem_gnt) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          // For a store this is just the ack; the captured value is unused
          ld_data_d = fmt_load(mem_rdata, req_off_q, req_size_q, req_uns_q);
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        // ls_ready drops here, so the EX/LS register advances at this edge
        wb_valid_d   = 1'b1;
        wb_pc_d      = ls_pc;
        wb_inst_d    = ls_inst;
        wb_rd_addr_d = ls_rd_addr;
        wb_wbctl_d   = ls_wbctl;
        wb_rd_ena_d  = req_wen_q ? 1'b0 : ls_rd_ena;
        wb_rd_data_d = req_wen_q ? ls_exu_res : ld_data_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and data registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      req_wen_q    <= 1'b0;
      req_wmask_q  <= 4'b0000;
      req_wdata_q  <= '0;
      req_size_q   <= SZ_B;
      req_uns_q    <= 1'b0;
      req_off_q    <= 2'b00;
      ld_data_q    <= '0;
      wb_valid_q   <= 1'b0;
      wb_pc_q      <= '0;
      wb_inst_q    <= '0;
      wb_rd_ena_q  <= 1'b0;
      wb_rd_addr_q <= 5'd0;
      wb_rd_data_q <= '0;
      wb_wbctl_q   <= 2'b00;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_wen_q    <= req_wen_d;
      req_wmask_q  <= req_wmask_d;
      req_wdata_q  <= req_wdata_d;
      req_size_q   <= req_size_d;
      req_uns_q    <= req_uns_d;
      req_off_q    <= req_off_d;
      ld_data_q    <= ld_data_d;
      wb_valid_q   <= wb_valid_d;
      wb_pc_q      <= wb_pc_d;
      wb_inst_q    <= wb_inst_d;
      wb_rd_ena_q  <= wb_rd_ena_d;
      wb_rd_addr_q <= wb_rd_addr_d;
      wb_rd_data_q <= wb_rd_data_d;
      wb_wbctl_q   <= wb_wbctl_d;
      misalign_q   <= misalign_d;
    end
  end

  // Gating with rst makes the request and the hold drop in the same cycle
  // reset is applied, rather than one edge later.
  assign ls_ready     = rst & busy;
  assign mem_req      = rst & (state_q == S_REQ);
  assign mem_addr     = req_addr_q;
  assign mem_wen      = req_wen_q;
  assign mem_wdata    = req_wdata_q;
  assign mem_wmask    = req_wmask_q;

  assign wb_valid     = wb_valid_q;
  assign wb_pc        = wb_pc_q;
  assign wb_inst      = wb_inst_q;
  assign wb_rd_ena    = wb_rd_ena_q;
  assign wb_rd_addr   = wb_rd_addr_q;
  assign wb_rd_data   = wb_rd_data_q;
  assign wb_wbctl     = wb_wbctl_q;
  assign lsu_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25060170_lsu
//
// Directed self-checking bench for the load/store unit. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_25060170_lsu;

  logic        clk;
  logic        rst;
  logic [31:0] ls_inst;
  logic [31:0] ls_pc;
  logic [31:0] ls_exu_res;
  logic [31:0] ls_store_data;
  logic [3:0]  ls_lsctl;
  logic [1:0]  ls_wbctl;
  logic        ls_rd_ena;
  logic [4:0]  ls_rd_addr;
  logic        ls_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_rd_ena;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data;
  logic [1:0]  wb_wbctl;
  logic        lsu_misalign;

  int pass_cnt = 0;
  int total    = 0;

  ysyx_25060170_lsu #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ls_inst      (ls_inst),
    .ls_pc        (ls_pc),
    .ls_exu_res   (ls_exu_res),
    .ls_store_data(ls_store_data),
    .ls_lsctl     (ls_lsctl),
    .ls_wbctl     (ls_wbctl),
    .ls_rd_ena    (ls_rd_ena),
    .ls_rd_addr   (ls_rd_addr),
    .ls_ready     (ls_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_inst      (wb_inst),
    .wb_rd_ena    (wb_rd_ena),
    .wb_rd_addr   (wb_rd_addr),
    .wb_rd_data   (wb_rd_data),
    .wb_wbctl     (wb_wbctl),
    .lsu_misalign (lsu_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic bubble();
    ls_inst    = 32'h0;
    ls_lsctl   = 4'b0000;
    ls_rd_ena  = 1'b0;
    ls_rd_addr = 5'd0;
    ls_exu_res = 32'h0;
  endtask

  // One memory op with grant in the first REQ cycle and rvalid in the first
  // RESP cycle; checks the 4-cycle latency and the formatted result.
  task automatic mem_op(input string tag, input logic [3:0] ctl,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd, input logic exp_ena);
    @(negedge clk);
    ls_inst = 32'h0000_2003; ls_pc = 32'h8000_0100; ls_lsctl = ctl;
    ls_exu_res = addr; ls_store_data = sd; ls_rd_ena = 1'b1; ls_rd_addr = 5'd9;
    ls_wbctl = 2'b01; mem_gnt = 1'b1; mem_rvalid = 1'b0;
    #1;
    chk({tag, " idle ready"}, 32'(ls_ready), 32'd1);
    chk({tag, " idle req"},   32'(mem_req),  32'd0);
    @(negedge clk);  // REQ
    chk({tag, " req"},   32'(mem_req), 32'd1);
    chk({tag, " addr"},  mem_addr, {addr[31:2], 2'b00});
    chk({tag, " wen"},   32'(mem_wen), 32'(ctl[3]));
    if (ctl[3]) begin
      chk({tag, " wmask"}, 32'(mem_wmask), 32'(exp_mask));
      chk({tag, " wdata"}, mem_wdata, exp_wdata);
    end
    @(negedge clk);  // RESP
    chk({tag, " resp ready"}, 32'(ls_ready), 32'd1);
    chk({tag, " resp req"},   32'(mem_req),  32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    @(negedge clk);  // DONE
    mem_rvalid = 1'b0;
    chk({tag, " done ready"}, 32'(ls_ready), 32'd0);
    chk({tag, " done wbv"},   32'(wb_valid), 32'd0);
    @(negedge clk);
    chk({tag, " wb_valid"},   32'(wb_valid),   32'd1);
    chk({tag, " rd_data"},    wb_rd_data,      exp_rd);
    chk({tag, " rd_ena"},     32'(wb_rd_ena),  32'(exp_ena));
    chk({tag, " rd_addr"},    32'(wb_rd_addr), 32'd9);
    bubble();
  endtask

  initial begin
    rst = 1'b0; bubble(); ls_pc = 32'h0; ls_store_data = 32'h0; ls_wbctl = 2'b00;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // Reset held for two cycles with grant asserted
    @(negedge clk); @(negedge clk);
    chk("rst wb_valid", 32'(wb_valid),     32'd0);
    chk("rst rd_data",  wb_rd_data,        32'd0);
    chk("rst misalign", 32'(lsu_misalign), 32'd0);
    chk("rst ready",    32'(ls_ready),     32'd0);
    chk("rst mem_req",  32'(mem_req),      32'd0);
    chk("rst mem_addr", mem_addr,          32'd0);
    chk("rst wmask",    32'(mem_wmask),    32'd0);
    rst = 1'b1;

    // ALU pass-through
    ls_inst = 32'h0010_0093; ls_pc = 32'h8000_0000; ls_lsctl = 4'b0000;
    ls_exu_res = 32'h1234; ls_rd_ena = 1'b1; ls_rd_addr = 5'd5; ls_wbctl = 2'b10;
    #1 chk("alu ready", 32'(ls_ready), 32'd0);
    @(negedge clk);
    chk("alu wb_valid", 32'(wb_valid),   32'd1);
    chk("alu rd_data",  wb_rd_data,      32'h1234);
    chk("alu rd_addr",  32'(wb_rd_addr), 32'd5);
    chk("alu wbctl",    32'(wb_wbctl),   32'd2);
    chk("alu ready2",   32'(ls_ready),   32'd0);
    bubble();
    @(negedge clk);
    chk("bubble wb_valid", 32'(wb_valid), 32'd0);

    // Loads and stores with minimum latency
    mem_op("LB",  4'b0001, 32'h8000_0003, 32'h0, 32'h80FF_1234, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1);
    mem_op("LBU", 4'b0100, 32'h8000_0003, 32'h0, 32'h80FF_1234, 4'h0, 32'h0, 32'h0000_0080, 1'b1);
    mem_op("LH",  4'b0010, 32'h8000_0002, 32'h0, 32'h80FF_1234, 4'h0, 32'h0, 32'hFFFF_80FF, 1'b1);
    mem_op("LHU", 4'b0101, 32'h8000_0000, 32'h0, 32'h80FF_8234, 4'h0, 32'h0, 32'h0000_8234, 1'b1);
    mem_op("SB",  4'b1001, 32'h8000_0001, 32'h1234_56A5, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h8000_0001, 1'b0);
    mem_op("SW",  4'b1011, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h8000_0008, 1'b0);

    // SH upper half, grant delayed three cycles
    @(negedge clk);
    ls_inst = 32'h0000_1023; ls_lsctl = 4'b1010; ls_exu_res = 32'h8000_0102;
    ls_store_data = 32'hDEAD_BEEF; ls_rd_ena = 1'b1; ls_rd_addr = 5'd3; mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("SH req held", 32'(mem_req),   32'd1);
      chk("SH wmask",    32'(mem_wmask), 32'hC);
      chk("SH wdata",    mem_wdata,      32'hBEEF_BEEF);
      chk("SH addr",     mem_addr,       32'h8000_0100);
      if (c == 3) mem_gnt = 1'b1;
    end
    @(negedge clk);
    chk("SH resp req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("SH wb_valid", 32'(wb_valid),  32'd1);
    chk("SH rd_ena",   32'(wb_rd_ena), 32'd0);
    chk("SH rd_data",  wb_rd_data,     32'h8000_0102);
    bubble();

    // Misaligned LW
    @(negedge clk);
    ls_inst = 32'h0000_2003; ls_lsctl = 4'b0011; ls_exu_res = 32'h8000_0006;
    ls_rd_ena = 1'b1; ls_rd_addr = 5'd4;
    #1;
    chk("mis ready", 32'(ls_ready), 32'd0);
    chk("mis req0",  32'(mem_req),  32'd0);
    @(negedge clk);
    chk("mis wb_valid", 32'(wb_valid),     32'd1);
    chk("mis flag",     32'(lsu_misalign), 32'd1);
    chk("mis rd_ena",   32'(wb_rd_ena),    32'd0);
    chk("mis req1",     32'(mem_req),      32'd0);
    bubble();
    @(negedge clk);
    chk("mis pulse end", 32'(lsu_misalign), 32'd0);
    chk("mis wbv end",   32'(wb_valid),     32'd0);

    // Reset while in REQ: mem_req drops in the same cycle
    ls_inst = 32'h0000_2003; ls_lsctl = 4'b0011; ls_exu_res = 32'h8000_0010;
    ls_rd_ena = 1'b1; ls_rd_addr = 5'd9; mem_gnt = 1'b0;
    @(negedge clk);
    chk("rreq req", 32'(mem_req), 32'd1);
    rst = 1'b0; bubble();
    #1 chk("rreq drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset while in RESP, then a stray rvalid
    ls_inst = 32'h0000_2003; ls_lsctl = 4'b0011; ls_exu_res = 32'h8000_0010;
    ls_rd_ena = 1'b1; ls_rd_addr = 5'd9; mem_gnt = 1'b1;
    @(negedge clk);  // REQ
    @(negedge clk);  // RESP
    chk("rresp req", 32'(mem_req), 32'd0);
    rst = 1'b0; bubble();
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray wbv",   32'(wb_valid), 32'd0);
    chk("stray req",   32'(mem_req),  32'd0);
    chk("stray ready", 32'(ls_ready), 32'd0);
    @(negedge clk);
    chk("stray wbv2",  32'(wb_valid), 32'd0);

    mem_op("LW", 4'b0011, 32'h8000_0020, 32'h0, 32'h1122_3344, 4'h0, 32'h0, 32'h1122_3344, 1'b1);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
